regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-port RISC-V integer register file: NRD async read ports, two sync write ports.
//  Array is cleared by a one-register-per-cycle sweep FSM after reset or on clr_req. A flop-reset
//  array is too costly at NREGS=32+. x0 is hardwired zero. Sits between decode (reads) and writeback
//  (port 0 = ALU, port 1 = load/late unit).
// PARAMETERS
//  XLEN  32  data width in bits
//  NREGS 32  number of architectural registers; power of two, >=2
//  NRD   2   number of read ports, 1..4
//  AW    $clog2(NREGS)  address width (derived, localparam)
// PORTS
//  clk      in   1         clock, rising edge
//  rst_n    in   1         synchronous reset, active-low
//  clr_req  in   1         request full clear sweep (honoured only in RUN)
//  ready    out  1         1 = sweep complete, reads/writes valid
//  we0      in   1         write enable, port 0
//  wrAddr0  in   AW        write address, port 0
//  wrData0  in   XLEN      write data, port 0
//  we1      in   1         write enable, port 1
//  wrAddr1  in   AW        write address, port 1
//  wrData1  in   XLEN      write data, port 1
//  rdAddr   in   NRD*AW    read addresses; port k = rdAddr[k*AW +: AW]
//  rdData   out  NRD*XLEN  read data; port k = rdData[k*XLEN +: XLEN]
// BEHAVIOUR
//  Clock clk; reset rst_n synchronous, active-low. No async reset anywhere.
//  FSM states: CLEAR, RUN. Sweep counter clr_idx (AW bits).
//  rst_n=0 at edge: state<=CLEAR, clr_idx<=1, ready<=0. Array contents untouched by reset itself.
//  CLEAR: each edge writes 0 to mem[clr_idx], clr_idx++. On the edge clearing NREGS-1: state<=RUN,
//   ready<=1. First edge with rst_n=1 clears x1, so ready is high NREGS-1 edges after that edge.
//  RUN: clr_req=1 at edge -> state<=CLEAR, clr_idx<=1, ready<=0; writes that edge are dropped.
//  clr_req in CLEAR ignored (sweep continues, no restart). rst_n=0 mid-sweep restarts at x1.
//  Writes: only in RUN with ready=1 and clr_req=0. Address 0 writes discarded.
//  we0 & we1 same nonzero address same edge: port 1 data wins. Different addresses: both commit.
//  Reads: combinational, rdData_k = mem[rdAddr_k]. Address 0 always returns 0.
//  While ready=0 every rdData port returns 0 (including reset cycles). Out-of-range impossible (pow2).
//  rdData reset value: 0 (forced by ready=0). ready reset value: 0.
//  Latency: write visible on reads the cycle after the committing edge (without bypass).
// CONFIGURATION
//  RF_BYPASS_EN defined: read port whose nonzero address matches an active, committable write in the
//   same cycle returns that write's data combinationally (port 1 over port 0 on double match).
//   Zero-latency write-to-read for the decode stage.
//  RF_BYPASS_EN undefined: no forwarding; same-cycle read returns the pre-write value.
//  Bypass never applies to x0, while ready=0, or when clr_req=1.
// TESTING
//  1 Reset: rst_n=0 2 cycles, release -> ready=0 for 31 edges, ready=1 after 31st; all rdData=0 meanwhile.
//  2 Dual write: we0 x5=32'h1111_0000, we1 x6=32'h0000_2222 same edge -> next cycle rd0(x5)=32'h1111_0000, rd1(x6)=32'h0000_2222.
//  3 Collision/x0: we0,we1 both x7 (32'hAAAA_AAAA / 32'h5555_5555) -> x7=32'h5555_5555; write x0=32'hDEADBEEF -> rd x0=0.
//  4 Bypass: we0 x9=32'hCAFE_F00D, rdAddr0=9 same cycle -> rdData0=32'hCAFE_F00D with RF_BYPASS_EN, old value without.
//  5 Clear: write x3=32'h0000_0003, pulse clr_req -> ready low 31 edges, write during sweep dropped, x3 reads 0 after.
//  6 Reset mid-sweep: rst_n=0 at clr_idx=10 -> sweep restarts at x1, ready asserts 31 edges after release.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port RISC-V integer register file: NRD async read ports, two sync write ports, sweep-cleared array.
// Optional same-cycle write-to-read forwarding is enabled by defining RF_BYPASS_EN.
`timescale 1ns/1ps
module regfile_mp #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  parameter int unsigned NRD   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_req,
  output logic                  ready,
  input  logic                  we0,
  input  logic [$clog2(NREGS)-1:0] wrAddr0,
  input  logic [XLEN-1:0]       wrData0,
  input  logic                  we1,
  input  logic [$clog2(NREGS)-1:0] wrAddr1,
  input  logic [XLEN-1:0]       wrData1,
  input  logic [NRD*$clog2(NREGS)-1:0] rdAddr,
  output logic [NRD*XLEN-1:0]   rdData
);

  localparam int unsigned AW = $clog2(NREGS);
  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

  state_t        state, stateNext;
  logic [AW-1:0] clrIdx, clrIdxNext;
  logic          readyNext;
  logic          sweepWe;
  logic          commit;
  logic          wrEn0, wrEn1;

  logic [XLEN-1:0] mem [NREGS];

  // State register; reset restarts the sweep at x1 and leaves the array alone
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= CLEAR;
      clrIdx <= AW'(1);
      ready  <= 1'b0;
    end else begin
      state  <= stateNext;
      clrIdx <= clrIdxNext;
      ready  <= readyNext;
    end
  end

  // Next-state logic
  always_comb begin
    stateNext = state;
    case (state)
      CLEAR:   if (clrIdx == LAST_IDX) stateNext = RUN;
      RUN:     if (clr_req) stateNext = CLEAR;
      default: stateNext = CLEAR;
    endcase
  end

  // Output logic: sweep write strobe, counter update, ready, write qualification
  always_comb begin
    clrIdxNext = clrIdx;
    readyNext  = ready;
    sweepWe    = 1'b0;
    commit     = 1'b0;
    case (state)
      CLEAR: begin
        sweepWe    = 1'b1;
        clrIdxNext = clrIdx + AW'(1);
        readyNext  = (clrIdx == LAST_IDX);
      end
      RUN: begin
        if (clr_req) begin
          clrIdxNext = AW'(1);
          readyNext  = 1'b0;
        end else begin
          commit = ready;
        end
      end
      default: ;
    endcase
  end

  assign wrEn0 = commit && we0 && (wrAddr0 != '0);
  assign wrEn1 = commit && we1 && (wrAddr1 != '0);

  // Array update; port 1 is written last so it wins an address collision
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (sweepWe) begin
        mem[clrIdx] <= '0;
      end else begin
        if (wrEn0) mem[wrAddr0] <= wrData0;
        if (wrEn1) mem[wrAddr1] <= wrData1;
      end
    end
  end

  for (genvar k = 0; k < int'(NRD); k++) begin : gRd
    logic [AW-1:0]   addrK;
    logic [XLEN-1:0] wordK;

    assign addrK = rdAddr[k*AW +: AW];

    // x0 and the not-ready window both read as zero
    always_comb begin
      wordK = '0;
      if (ready && (addrK != '0)) begin
        wordK = mem[addrK];
`ifdef RF_BYPASS_EN
        if (wrEn1 && (wrAddr1 == addrK)) begin
          wordK = wrData1;
        end else if (wrEn0 && (wrAddr0 == addrK)) begin
          wordK = wrData0;
        end
`endif
      end
    end

    assign rdData[k*XLEN +: XLEN] = wordK;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (XLEN=32, NREGS=32, NRD=2).
// Bypass expectations follow RF_BYPASS_EN when the bench is built with it.
`timescale 1ns/1ps
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr_req;
  logic        ready;
  logic        we0, we1;
  logic [4:0]  wrAddr0, wrAddr1;
  logic [31:0] wrData0, wrData1;
  logic [9:0]  rdAddr;
  logic [63:0] rdData;

  int testsRun = 0;
  int testsFailed = 0;

  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2)) dut (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .ready(ready),
    .we0(we0), .wrAddr0(wrAddr0), .wrData0(wrData0),
    .we1(we1), .wrAddr1(wrAddr1), .wrData1(wrData1),
    .rdAddr(rdAddr), .rdData(rdData)
  );

  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge, then let combinational reads settle
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setRd(input logic [4:0] a0, input logic [4:0] a1);
    rdAddr = {a1, a0};
    #1;
  endtask

  task automatic idleWrites();
    we0 = 1'b0; we1 = 1'b0;
    wrAddr0 = '0; wrAddr1 = '0;
    wrData0 = '0; wrData1 = '0;
  endtask

  task automatic write0(input logic [4:0] a, input logic [31:0] d);
    we0 = 1'b1; wrAddr0 = a; wrData0 = d;
    step();
    idleWrites();
  endtask

  // Checks ready stays low for 30 edges and rises on the 31st
  task automatic sweepCheck(input string tag);
    for (int e = 1; e <= 31; e++) begin
      step();
      if (e == 30 || e == 31) checkEq(tag, {31'd0, ready}, {31'd0, (e == 31)});
      else if (ready) checkEq(tag, {31'd0, ready}, 32'd0);
    end
  endtask

  logic [31:0] expBypass, expDouble;

  initial begin
    rst_n = 1'b0; clr_req = 1'b0;
    idleWrites();
    rdAddr = {5'd6, 5'd5};

    // Reset held for two edges
    step(); step();
    checkEq("rst_ready", {31'd0, ready}, 32'd0);
    checkEq("rst_rd0", rdData[31:0], 32'd0);
    checkEq("rst_rd1", rdData[63:32], 32'd0);
    rst_n = 1'b1;
    sweepCheck("init_sweep");
    checkEq("post_sweep_rd0", rdData[31:0], 32'd0);

    // Dual write to distinct addresses
    we0 = 1'b1; wrAddr0 = 5'd5; wrData0 = 32'h1111_0000;
    we1 = 1'b1; wrAddr1 = 5'd6; wrData1 = 32'h0000_2222;
    step();
    idleWrites();
    setRd(5'd5, 5'd6);
    checkEq("dual_x5", rdData[31:0], 32'h1111_0000);
    checkEq("dual_x6", rdData[63:32], 32'h0000_2222);

    // Same-address collision: port 1 wins; x0 writes discarded
    we0 = 1'b1; wrAddr0 = 5'd7; wrData0 = 32'hAAAA_AAAA;
    we1 = 1'b1; wrAddr1 = 5'd7; wrData1 = 32'h5555_5555;
    step();
    idleWrites();
    we0 = 1'b1; wrAddr0 = 5'd0; wrData0 = 32'hDEAD_BEEF;
    we1 = 1'b1; wrAddr1 = 5'd0; wrData1 = 32'hDEAD_BEEF;
    step();
    idleWrites();
    setRd(5'd7, 5'd0);
    checkEq("collide_x7", rdData[31:0], 32'h5555_5555);
    checkEq("x0_zero", rdData[63:32], 32'd0);

    // Same-cycle read of an in-flight write
    write0(5'd9, 32'h0000_0009);
    we0 = 1'b1; wrAddr0 = 5'd9; wrData0 = 32'hCAFE_F00D;
    we1 = 1'b1; wrAddr1 = 5'd10; wrData1 = 32'h0000_00B1;
    setRd(5'd9, 5'd10);
`ifdef RF_BYPASS_EN
    expBypass = 32'hCAFE_F00D;
    expDouble = 32'h0000_00B1;
`else
    expBypass = 32'h0000_0009;
    expDouble = 32'h0000_0000;
`endif
    checkEq("bypass_x9", rdData[31:0], expBypass);
    checkEq("bypass_x10", rdData[63:32], expDouble);
    step();
    idleWrites();
    #1;
    checkEq("commit_x9", rdData[31:0], 32'hCAFE_F00D);
    checkEq("commit_x10", rdData[63:32], 32'h0000_00B1);

    // Both ports hitting x11 in the same cycle as a read
    we0 = 1'b1; wrAddr0 = 5'd11; wrData0 = 32'h0000_00A0;
    we1 = 1'b1; wrAddr1 = 5'd11; wrData1 = 32'h0000_00B0;
    setRd(5'd11, 5'd0);
`ifdef RF_BYPASS_EN
    expDouble = 32'h0000_00B0;
`else
    expDouble = 32'h0000_0000;
`endif
    checkEq("bypass_double", rdData[31:0], expDouble);
    checkEq("bypass_x0", rdData[63:32], 32'd0);
    step();
    idleWrites();

    // Clear request: sweep drops writes, ignores a second clr_req, zeroes the array
    write0(5'd3, 32'h0000_0003);
    setRd(5'd3, 5'd9);
    checkEq("pre_clr_x3", rdData[31:0], 32'h0000_0003);
    clr_req = 1'b1;
    we1 = 1'b1; wrAddr1 = 5'd12; wrData1 = 32'h0000_0012;
    step();
    clr_req = 1'b0;
    idleWrites();
    checkEq("clr_ready_low", {31'd0, ready}, 32'd0);
    for (int e = 1; e <= 31; e++) begin
      step();
      clr_req = 1'b0;
      idleWrites();
      if (e == 30 || e == 31) checkEq("clr_sweep", {31'd0, ready}, {31'd0, (e == 31)});
      else if (ready) checkEq("clr_sweep", {31'd0, ready}, 32'd0);
      if (e == 20) checkEq("clr_rd_gated", rdData[63:32], 32'd0);
      if (e == 5) begin
        we0 = 1'b1; wrAddr0 = 5'd3; wrData0 = 32'h0000_0077;
      end
      if (e == 10) clr_req = 1'b1;
    end
    setRd(5'd3, 5'd9);
    checkEq("clr_x3", rdData[31:0], 32'd0);
    checkEq("clr_x9", rdData[63:32], 32'd0);
    setRd(5'd12, 5'd7);
    checkEq("clr_x12", rdData[31:0], 32'd0);
    checkEq("clr_x7", rdData[63:32], 32'd0);

    // Reset mid-sweep restarts from x1
    write0(5'd12, 32'h0000_0C0C);
    write0(5'd20, 32'h0000_1414);
    setRd(5'd12, 5'd20);
    checkEq("pre_rst_x12", rdData[31:0], 32'h0000_0C0C);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int e = 1; e <= 9; e++) step();
    rst_n = 1'b0;
    step();
    checkEq("mid_rst_ready", {31'd0, ready}, 32'd0);
    rst_n = 1'b1;
    sweepCheck("rst_sweep");
    setRd(5'd12, 5'd20);
    checkEq("rst_x12", rdData[31:0], 32'd0);
    checkEq("rst_x20", rdData[63:32], 32'd0);
    write0(5'd20, 32'h0000_2020);
    setRd(5'd20, 5'd1);
    checkEq("post_rst_wr", rdData[31:0], 32'h0000_2020);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
